// File: rtl/cache_set_store_pkg.sv
// Shared types and constants for the cache set store and the stages around it.
package cache_set_store_pkg;

  localparam int SETS     = 16384;
  localparam int D_WAYS   = 8;
  localparam int I_WAYS   = 4;
  localparam int TAG_W    = 12;
  localparam int SET_W    = 14;
  localparam int OFFSET_W = 6;
  localparam int CNT_W    = 32;
  // Wide enough to name any way of the larger (data) cache.
  localparam int LRU_W    = $clog2(D_WAYS);

  typedef enum logic [1:0] {
    MESI_I = 2'd0,
    MESI_S = 2'd1,
    MESI_E = 2'd2,
    MESI_M = 2'd3
  } mesi_t;

  typedef enum logic [3:0] {
    READ_D   = 4'd0,
    WRITE_D  = 4'd1,
    FETCH_I  = 4'd2,
    INVAL    = 4'd3,
    SNOOP_RD = 4'd4,
    CLEAR    = 4'd8,
    PRINT    = 4'd9
  } cmd_code_t;

  typedef struct packed {
    logic [TAG_W-1:0]    tag;
    logic [SET_W-1:0]    index;
    logic [OFFSET_W-1:0] offset;
  } address_t;

  typedef struct packed {
    logic [3:0] n;
    address_t   address;
  } command_t;

  typedef struct packed {
    mesi_t             mesi;
    logic [TAG_W-1:0]  tag;
    logic [LRU_W-1:0]  lru;
  } cache_line_t;

  typedef enum logic [1:0] {
    ST_CLEAR        = 2'd0,
    ST_IDLE         = 2'd1,
    ST_LOOKUP       = 2'd2,
    ST_COMMIT_PRINT = 2'd3
  } state_t;

  // Commands that read a set and hand it to the processor stage.
  function automatic logic is_lookup_cmd(logic [3:0] n);
    return n <= 4'(SNOOP_RD);
  endfunction

  // Contents a way takes after a sweep: invalid, zero tag, LRU rank = way.
  function automatic cache_line_t cleared_line(int unsigned way);
    cache_line_t l;
    l.mesi = MESI_I;
    l.tag  = '0;
    l.lru  = LRU_W'(way);
    return l;
  endfunction

endpackage

// File: rtl/cache_set_store_if.sv
// Command, processor-stage and statistics signals of the cache set store.
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high; the source holds cmd stable while cmd_valid is
// high and cmd_ready low. cmd_out/current_line_* are meaningful only while
// cmd_out_valid is high, and return_line_* are sampled at the edge that
// closes that cycle.
interface cache_set_store_if #(parameter int CNT_W = 32);
  import cache_set_store_pkg::*;

  logic                            cmd_valid;
  logic                            cmd_ready;
  command_t                        cmd;
  command_t                        cmd_out;
  logic                            cmd_out_valid;
  cache_line_t [I_WAYS-1:0]        current_line_i;
  cache_line_t [D_WAYS-1:0]        current_line_d;
  cache_line_t [I_WAYS-1:0]        return_line_i;
  cache_line_t [D_WAYS-1:0]        return_line_d;
  logic                            print_req;
  logic                            busy;
  logic [CNT_W-1:0]                read_cnt;
  logic [CNT_W-1:0]                write_cnt;
  logic [CNT_W-1:0]                hit_cnt;
  logic [CNT_W-1:0]                miss_cnt;
  state_t                          dbg_state;

  modport slave (
    input  cmd_valid, cmd, return_line_i, return_line_d,
    output cmd_ready, cmd_out, cmd_out_valid, current_line_i, current_line_d,
           print_req, busy, read_cnt, write_cnt, hit_cnt, miss_cnt, dbg_state
  );

  modport master (
    output cmd_valid, cmd, return_line_i, return_line_d,
    input  cmd_ready, cmd_out, cmd_out_valid, current_line_i, current_line_d,
           print_req, busy, read_cnt, write_cnt, hit_cnt, miss_cnt, dbg_state
  );

endinterface

// File: rtl/cache_stats_counter.sv
// Saturating statistics counter with synchronous clear.
module cache_stats_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q, count_d;

  // Clear wins over increment; stick at all-ones instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/cache_set_store.sv
// Holds the instruction and data cache sets, presents the indexed set to the
// processor stage for one cycle per command, commits the returned lines, and
// sweeps all sets to a known state after reset or a clear command.
module cache_set_store #(
  parameter int SETS  = cache_set_store_pkg::SETS,
  parameter int CNT_W = cache_set_store_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  cache_set_store_if.slave bus
);
  import cache_set_store_pkg::*;

  localparam int IDX_W = $clog2(SETS);

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         clr_ptr_q, clr_ptr_d;
  command_t                 cmd_out_q, cmd_out_d;
  cache_line_t [I_WAYS-1:0] cur_i_q, cur_i_d;
  cache_line_t [D_WAYS-1:0] cur_d_q, cur_d_d;

  cache_line_t [I_WAYS-1:0] mem_i [SETS];
  cache_line_t [D_WAYS-1:0] mem_d [SETS];

  logic                     accept;
  logic                     load_cur;
  logic                     cnt_clr;
  logic [IDX_W-1:0]         acc_idx;
  logic [IDX_W-1:0]         out_idx;

  logic                     wr_i_en, wr_d_en;
  logic [IDX_W-1:0]         wr_i_idx, wr_d_idx;
  cache_line_t [I_WAYS-1:0] wr_i_data, clr_set_i;
  cache_line_t [D_WAYS-1:0] wr_d_data, clr_set_d;

  logic                     hit;
  logic                     stat_cmd;
  logic                     hit_inc, miss_inc, read_inc, write_inc;

  assign accept  = bus.cmd_valid && (state_q == ST_IDLE);
  assign acc_idx = bus.cmd.address.index[IDX_W-1:0];
  assign out_idx = cmd_out_q.address.index[IDX_W-1:0];

  // Set images written by the sweep.
  always_comb begin
    for (int w = 0; w < I_WAYS; w++) clr_set_i[w] = cleared_line(w);
    for (int w = 0; w < D_WAYS; w++) clr_set_d[w] = cleared_line(w);
  end

  // Next-state logic: sweep, accept/decode, one-cycle lookup and print.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    cmd_out_d = cmd_out_q;
    load_cur  = 1'b0;
    cnt_clr   = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == IDX_W'(SETS - 1)) begin
          clr_ptr_d = '0;
          state_d   = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (accept) begin
          cmd_out_d = bus.cmd;
          if (is_lookup_cmd(bus.cmd.n)) begin
            load_cur = 1'b1;
            state_d  = ST_LOOKUP;
          end else if (bus.cmd.n == 4'(CLEAR)) begin
            cnt_clr  = 1'b1;
            state_d  = ST_CLEAR;
          end else if (bus.cmd.n == 4'(PRINT)) begin
            state_d  = ST_COMMIT_PRINT;
          end
          // Unknown codes are consumed and ignored.
        end
      end
      ST_LOOKUP:       state_d = ST_IDLE;
      ST_COMMIT_PRINT: state_d = ST_IDLE;
      default:         state_d = ST_CLEAR;
    endcase
  end

  // Latch the indexed sets on accept; the lookup cycle sees a stable copy.
  always_comb begin
    cur_i_d = cur_i_q;
    cur_d_d = cur_d_q;
    if (load_cur) begin
      cur_i_d = mem_i[acc_idx];
      cur_d_d = mem_d[acc_idx];
    end
  end

  // State, sweep pointer, latched command and presented sets.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
      cmd_out_q <= '0;
      cur_i_q   <= '0;
      cur_d_q   <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      cmd_out_q <= cmd_out_d;
      cur_i_q   <= cur_i_d;
      cur_d_q   <= cur_d_d;
    end
  end

  // Storage write select: the sweep writes both caches, a lookup commits
  // only the cache its command targets.
  always_comb begin
    wr_i_en   = 1'b0;
    wr_d_en   = 1'b0;
    wr_i_idx  = out_idx;
    wr_d_idx  = out_idx;
    wr_i_data = bus.return_line_i;
    wr_d_data = bus.return_line_d;
    if (state_q == ST_CLEAR) begin
      wr_i_en   = 1'b1;
      wr_d_en   = 1'b1;
      wr_i_idx  = clr_ptr_q;
      wr_d_idx  = clr_ptr_q;
      wr_i_data = clr_set_i;
      wr_d_data = clr_set_d;
    end else if (state_q == ST_LOOKUP) begin
      if (cmd_out_q.n == 4'(FETCH_I)) begin
        wr_i_en = 1'b1;
      end else begin
        wr_d_en = 1'b1;
      end
    end
  end

  // Set storage; contents are defined by the sweep rather than by reset.
  always_ff @(posedge clk) begin
    if (wr_i_en) mem_i[wr_i_idx] <= wr_i_data;
    if (wr_d_en) mem_d[wr_d_idx] <= wr_d_data;
  end

  // Hit: a valid way of the targeted cache holds the command's tag.
  always_comb begin
    hit = 1'b0;
    if (cmd_out_q.n == 4'(FETCH_I)) begin
      for (int w = 0; w < I_WAYS; w++) begin
        if ((cur_i_q[w].mesi != MESI_I) && (cur_i_q[w].tag == cmd_out_q.address.tag)) hit = 1'b1;
      end
    end else begin
      for (int w = 0; w < D_WAYS; w++) begin
        if ((cur_d_q[w].mesi != MESI_I) && (cur_d_q[w].tag == cmd_out_q.address.tag)) hit = 1'b1;
      end
    end
  end

  // Statistics events, all taken at the edge closing the lookup cycle.
  always_comb begin
    stat_cmd  = (state_q == ST_LOOKUP) && (cmd_out_q.n <= 4'(FETCH_I));
    hit_inc   = stat_cmd && hit;
    miss_inc  = stat_cmd && !hit;
    read_inc  = (state_q == ST_LOOKUP) &&
                ((cmd_out_q.n == 4'(READ_D)) || (cmd_out_q.n == 4'(FETCH_I)));
    write_inc = (state_q == ST_LOOKUP) && (cmd_out_q.n == 4'(WRITE_D));
  end

  cache_stats_counter #(.CNT_W(CNT_W)) u_read_cnt (
    .clk(clk), .rst(rst), .clr_i(cnt_clr), .inc_i(read_inc), .count_o(bus.read_cnt)
  );
  cache_stats_counter #(.CNT_W(CNT_W)) u_write_cnt (
    .clk(clk), .rst(rst), .clr_i(cnt_clr), .inc_i(write_inc), .count_o(bus.write_cnt)
  );
  cache_stats_counter #(.CNT_W(CNT_W)) u_hit_cnt (
    .clk(clk), .rst(rst), .clr_i(cnt_clr), .inc_i(hit_inc), .count_o(bus.hit_cnt)
  );
  cache_stats_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk(clk), .rst(rst), .clr_i(cnt_clr), .inc_i(miss_inc), .count_o(bus.miss_cnt)
  );

  assign bus.cmd_ready      = (state_q == ST_IDLE);
  assign bus.busy           = (state_q == ST_CLEAR);
  assign bus.cmd_out_valid  = (state_q == ST_LOOKUP);
  assign bus.print_req      = (state_q == ST_COMMIT_PRINT);
  assign bus.cmd_out        = cmd_out_q;
  assign bus.current_line_i = cur_i_q;
  assign bus.current_line_d = cur_d_q;
  assign bus.dbg_state      = state_q;

endmodule

// File: tb/tb_cache_set_store.sv
// Bench for cache_set_store: directed scenarios plus randomized commands
// checked against an array-based model of the two caches and the counters.
module tb_cache_set_store;
  import cache_set_store_pkg::*;

  localparam int SETS_TB  = 256;
  localparam int SETS_SAT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_set_store_if #(.CNT_W(32)) bus();
  cache_set_store_if #(.CNT_W(2))  bus2();

  cache_set_store #(.SETS(SETS_TB), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );
  cache_set_store #(.SETS(SETS_SAT), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .bus(bus2.slave)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: set contents and counter values.
  cache_line_t [I_WAYS-1:0] m_i [SETS_TB];
  cache_line_t [D_WAYS-1:0] m_d [SETS_TB];
  longint e_read, e_write, e_hit, e_miss;
  logic [11:0] tag_pool [3] = '{12'h011, 12'h022, 12'h033};

  function automatic cache_line_t mk_line(mesi_t m, logic [11:0] t, int lru);
    cache_line_t l;
    l.mesi = m; l.tag = t; l.lru = 3'(lru);
    return l;
  endfunction

  function automatic cache_line_t [I_WAYS-1:0] clr_i_set();
    cache_line_t [I_WAYS-1:0] s;
    for (int w = 0; w < I_WAYS; w++) s[w] = mk_line(MESI_I, 12'h000, w);
    return s;
  endfunction

  function automatic cache_line_t [D_WAYS-1:0] clr_d_set();
    cache_line_t [D_WAYS-1:0] s;
    for (int w = 0; w < D_WAYS; w++) s[w] = mk_line(MESI_I, 12'h000, w);
    return s;
  endfunction

  function automatic cache_line_t rand_line();
    return mk_line(mesi_t'($urandom_range(0, 3)), tag_pool[$urandom_range(0, 2)],
                   int'($urandom_range(0, 7)));
  endfunction

  function automatic longint sat(longint v);
    return (v == 64'hFFFF_FFFF) ? v : v + 1;
  endfunction

  task automatic model_sweep();
    for (int s = 0; s < SETS_TB; s++) begin
      m_i[s] = clr_i_set();
      m_d[s] = clr_d_set();
    end
    e_read = 0; e_write = 0; e_hit = 0; e_miss = 0;
  endtask

  function automatic bit model_hit(logic [3:0] n, int idx, logic [11:0] tag);
    bit h = 0;
    if (n == 4'd2) begin
      for (int w = 0; w < I_WAYS; w++) if (m_i[idx][w].mesi != MESI_I && m_i[idx][w].tag == tag) h = 1;
    end else begin
      for (int w = 0; w < D_WAYS; w++) if (m_d[idx][w].mesi != MESI_I && m_d[idx][w].tag == tag) h = 1;
    end
    return h;
  endfunction

  // Driver + scoreboard: issue one command, check what the DUT presents,
  // advance the model, then check the counters one cycle later.
  task automatic do_cmd(input logic [3:0] n, input logic [31:0] addr,
                        input cache_line_t [I_WAYS-1:0] ri, input cache_line_t [D_WAYS-1:0] rd);
    command_t c;
    int waitc = 0;
    int idx;
    logic [11:0] tag;
    bit h;
    c.n = n; c.address = addr;
    idx = int'((addr >> 6) % SETS_TB);
    tag = addr[31:20];
    @(negedge clk);
    while (bus.cmd_ready !== 1'b1 && waitc < 4 * SETS_TB) begin @(negedge clk); waitc++; end
    if (bus.cmd_ready !== 1'b1) begin
      total_cnt++;
      $display("FAIL cmd_ready_timeout: got %b required 1", bus.cmd_ready);
      return;
    end
    bus.cmd = c; bus.cmd_valid = 1'b1;
    bus.return_line_i = ri; bus.return_line_d = rd;
    @(posedge clk); #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (bus.cmd_out !== c) $display("FAIL cmd_out: got %h required %h", bus.cmd_out, c); else pass_cnt++;
    if (n <= 4'd4) begin
      total_cnt++;
      if (bus.cmd_out_valid !== 1'b1) $display("FAIL cmd_out_valid_lookup: got %b required 1", bus.cmd_out_valid); else pass_cnt++;
      total_cnt++;
      if (bus.current_line_i !== m_i[idx]) $display("FAIL current_line_i: got %h required %h", bus.current_line_i, m_i[idx]); else pass_cnt++;
      total_cnt++;
      if (bus.current_line_d !== m_d[idx]) $display("FAIL current_line_d: got %h required %h", bus.current_line_d, m_d[idx]); else pass_cnt++;
      h = model_hit(n, idx, tag);
      if (n == 4'd2) m_i[idx] = ri; else m_d[idx] = rd;
      if (n <= 4'd2) begin if (h) e_hit = sat(e_hit); else e_miss = sat(e_miss); end
      if (n == 4'd0 || n == 4'd2) e_read = sat(e_read);
      if (n == 4'd1) e_write = sat(e_write);
    end else if (n == 4'd9) begin
      total_cnt++;
      if (bus.print_req !== 1'b1) $display("FAIL print_req_pulse: got %b required 1", bus.print_req); else pass_cnt++;
    end else if (n == 4'd8) begin
      model_sweep();
      total_cnt++;
      if (bus.busy !== 1'b1) $display("FAIL busy_after_clear: got %b required 1", bus.busy); else pass_cnt++;
    end else begin
      total_cnt++;
      if (bus.cmd_ready !== 1'b1) $display("FAIL illegal_stays_idle: got %b required 1", bus.cmd_ready); else pass_cnt++;
    end
    @(negedge clk);
    total_cnt++;
    if (bus.cmd_out_valid !== 1'b0 || bus.print_req !== 1'b0)
      $display("FAIL outputs_after_cmd: valid %b print %b required 0 0", bus.cmd_out_valid, bus.print_req);
    else pass_cnt++;
    total_cnt++;
    if (bus.read_cnt !== e_read[31:0] || bus.write_cnt !== e_write[31:0] ||
        bus.hit_cnt !== e_hit[31:0] || bus.miss_cnt !== e_miss[31:0])
      $display("FAIL counters n=%0d: got r%0d w%0d h%0d m%0d required r%0d w%0d h%0d m%0d", n,
               bus.read_cnt, bus.write_cnt, bus.hit_cnt, bus.miss_cnt, e_read, e_write, e_hit, e_miss);
    else pass_cnt++;
  endtask

  // Count busy cycles from the current point, flagging any cmd_ready.
  task automatic count_busy(output int cycles, output bit ready_seen);
    cycles = 0; ready_seen = 0;
    @(negedge clk);
    while (bus.busy === 1'b1 && cycles < 4 * SETS_TB) begin
      cycles++;
      if (bus.cmd_ready !== 1'b0) ready_seen = 1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int cyc; bit rdy;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (bus.read_cnt !== 0 || bus.write_cnt !== 0 || bus.hit_cnt !== 0 || bus.miss_cnt !== 0)
      $display("FAIL reset_counters: got %0d %0d %0d %0d required 0", bus.read_cnt, bus.write_cnt, bus.hit_cnt, bus.miss_cnt);
    else pass_cnt++;
    total_cnt++;
    if (bus.cmd_out !== '0 || bus.current_line_i !== '0 || bus.current_line_d !== '0)
      $display("FAIL reset_regs: got cmd %h li %h ld %h required 0", bus.cmd_out, bus.current_line_i, bus.current_line_d);
    else pass_cnt++;
    total_cnt++;
    if (bus.cmd_ready !== 1'b0 || bus.cmd_out_valid !== 1'b0 || bus.print_req !== 1'b0 || bus.busy !== 1'b1)
      $display("FAIL reset_flags: got rdy%b val%b prn%b busy%b required 0 0 0 1",
               bus.cmd_ready, bus.cmd_out_valid, bus.print_req, bus.busy);
    else pass_cnt++;
    @(posedge clk); #1 rst = 1'b0;
    count_busy(cyc, rdy);
    total_cnt++;
    if (cyc != SETS_TB) $display("FAIL reset_sweep_len: got %0d required %0d", cyc, SETS_TB); else pass_cnt++;
    total_cnt++;
    if (rdy) $display("FAIL ready_during_sweep: got 1 required 0"); else pass_cnt++;
    model_sweep();
    do_cmd(4'd3, 32'h0000_0000, clr_i_set(), clr_d_set());
    total_cnt++;
    if (bus.current_line_d[D_WAYS-1].lru !== 3'(D_WAYS-1) || bus.current_line_d[D_WAYS-1].mesi !== MESI_I ||
        bus.current_line_i[I_WAYS-1].lru !== 3'(I_WAYS-1))
      $display("FAIL swept_set0: got d %h i %h required lru=way mesi=I", bus.current_line_d, bus.current_line_i);
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    command_t c;
    int waitc;
    c.n = 4'd0; c.address = 32'h0;
    for (int k = 0; k < 5; k++) begin
      waitc = 0;
      @(negedge clk);
      while (bus2.cmd_ready !== 1'b1 && waitc < 4 * SETS_SAT) begin @(negedge clk); waitc++; end
      bus2.cmd = c; bus2.cmd_valid = 1'b1;
      bus2.return_line_i = clr_i_set(); bus2.return_line_d = clr_d_set();
      @(posedge clk); #1 bus2.cmd_valid = 1'b0;
    end
    repeat (2) @(negedge clk);
    total_cnt++;
    if (bus2.miss_cnt !== 2'd3 || bus2.read_cnt !== 2'd3 || bus2.hit_cnt !== 2'd0)
      $display("FAIL saturation: got m%0d r%0d h%0d required m3 r3 h0", bus2.miss_cnt, bus2.read_cnt, bus2.hit_cnt);
    else pass_cnt++;
  endtask

  task automatic test_miss_hit();
    cache_line_t [D_WAYS-1:0] rd;
    rd = clr_d_set();
    rd[7] = mk_line(MESI_E, 12'h123, 7);
    do_cmd(4'd0, 32'h1234_5678, clr_i_set(), rd);
    total_cnt++;
    if (bus.miss_cnt !== 1 || bus.read_cnt !== 1 || bus.hit_cnt !== 0)
      $display("FAIL first_miss: got m%0d r%0d h%0d required m1 r1 h0", bus.miss_cnt, bus.read_cnt, bus.hit_cnt);
    else pass_cnt++;
    do_cmd(4'd0, 32'h1234_5678, clr_i_set(), rd);
    total_cnt++;
    if (bus.hit_cnt !== 1 || bus.miss_cnt !== 1 || bus.read_cnt !== 2)
      $display("FAIL second_hit: got h%0d m%0d r%0d required h1 m1 r2", bus.hit_cnt, bus.miss_cnt, bus.read_cnt);
    else pass_cnt++;
    total_cnt++;
    if (bus.current_line_d[7].tag !== 12'h123 || bus.current_line_d[7].mesi !== MESI_E)
      $display("FAIL committed_way7: got %h required tag 123 mesi E", bus.current_line_d[7]);
    else pass_cnt++;
  endtask

  task automatic test_isolation();
    cache_line_t [I_WAYS-1:0] ri;
    cache_line_t [D_WAYS-1:0] junk;
    for (int w = 0; w < I_WAYS; w++) ri[w] = mk_line(MESI_S, 12'h0AB, w);
    for (int w = 0; w < D_WAYS; w++) junk[w] = mk_line(MESI_M, 12'hFFF, 0);
    do_cmd(4'd2, 32'h0AB0_0140, ri, junk);
    do_cmd(4'd0, 32'h0AB0_0140, clr_i_set(), clr_d_set());
    total_cnt++;
    if (bus.current_line_d[0].tag !== 12'h000 || bus.current_line_i[0].tag !== 12'h0AB)
      $display("FAIL isolation: got d0 %h i0 %h required tag 000 / 0AB", bus.current_line_d[0], bus.current_line_i[0]);
    else pass_cnt++;
    total_cnt++;
    if (bus.write_cnt !== 0) $display("FAIL write_cnt_before: got %0d required 0", bus.write_cnt); else pass_cnt++;
    do_cmd(4'd1, 32'h0AB0_0140, clr_i_set(), clr_d_set());
    total_cnt++;
    if (bus.write_cnt !== 1) $display("FAIL write_cnt_after: got %0d required 1", bus.write_cnt); else pass_cnt++;
  endtask

  task automatic test_print_illegal();
    logic [31:0] r0, m0;
    r0 = bus.read_cnt; m0 = bus.miss_cnt;
    do_cmd(4'd9, 32'h0, clr_i_set(), clr_d_set());
    do_cmd(4'd6, 32'h0000_0040, clr_i_set(), clr_d_set());
    total_cnt++;
    if (bus.read_cnt !== r0 || bus.miss_cnt !== m0)
      $display("FAIL print_illegal_counters: got r%0d m%0d required r%0d m%0d", bus.read_cnt, bus.miss_cnt, r0, m0);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    command_t c;
    cache_line_t [D_WAYS-1:0] rd;
    int idx = 9, acc = 1, prev = 0, c_cyc = 0, waitc = 0;
    c.n = 4'd4; c.address = {12'h022, 14'(idx), 6'd0};
    @(negedge clk);
    while (bus.cmd_ready !== 1'b1 && waitc < 4 * SETS_TB) begin @(negedge clk); waitc++; end
    for (int w = 0; w < D_WAYS; w++) rd[w] = rand_line();
    bus.cmd = c; bus.cmd_valid = 1'b1; bus.return_line_d = rd;
    while (acc < 6 && c_cyc < 40) begin
      @(negedge clk); c_cyc++;
      if (bus.cmd_ready === 1'b1) begin
        total_cnt++;
        if (c_cyc - prev != 2) $display("FAIL b2b_gap: got %0d required 2", c_cyc - prev); else pass_cnt++;
        prev = c_cyc; acc++;
      end else if (bus.cmd_out_valid === 1'b1) begin
        total_cnt++;
        if (bus.current_line_d !== m_d[idx]) $display("FAIL b2b_visibility: got %h required %h", bus.current_line_d, m_d[idx]); else pass_cnt++;
        for (int w = 0; w < D_WAYS; w++) rd[w] = rand_line();
        bus.return_line_d = rd; m_d[idx] = rd;
      end
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    total_cnt++;
    if (bus.cmd_out_valid !== 1'b1 || bus.current_line_d !== m_d[idx])
      $display("FAIL b2b_last: got valid %b d %h required 1 %h", bus.cmd_out_valid, bus.current_line_d, m_d[idx]);
    else pass_cnt++;
    for (int w = 0; w < D_WAYS; w++) rd[w] = rand_line();
    bus.return_line_d = rd; m_d[idx] = rd;
    total_cnt++;
    if (acc != 6) $display("FAIL b2b_accepts: got %0d required 6", acc); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_clear();
    int cyc; bit rdy;
    do_cmd(4'd8, 32'h0, clr_i_set(), clr_d_set());
    count_busy(cyc, rdy);
    total_cnt++;
    if (cyc + 2 != SETS_TB) $display("FAIL clear_sweep_len: got %0d required %0d", cyc + 2, SETS_TB); else pass_cnt++;
    do_cmd(4'd3, 32'h1234_5678, clr_i_set(), clr_d_set());
    total_cnt++;
    if (bus.current_line_d[7].tag !== 12'h000 || bus.current_line_d[7].mesi !== MESI_I)
      $display("FAIL clear_tags_gone: got %h required tag 0 mesi I", bus.current_line_d[7]);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [3:0] codes [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd9};
    cache_line_t [I_WAYS-1:0] ri;
    cache_line_t [D_WAYS-1:0] rd;
    logic [31:0] addr;
    for (int k = 0; k < 60; k++) begin
      for (int w = 0; w < I_WAYS; w++) ri[w] = rand_line();
      for (int w = 0; w < D_WAYS; w++) rd[w] = rand_line();
      addr = {tag_pool[$urandom_range(0, 2)], 14'($urandom_range(20, 23)), 6'($urandom_range(0, 63))};
      do_cmd(codes[$urandom_range(0, 6)], addr, ri, rd);
    end
  endtask

  task automatic test_mid_reset();
    int cyc = 0; bit rdy;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    while (bus.busy === 1'b1 && cyc < 100) begin cyc++; @(negedge clk); end
    total_cnt++;
    if (cyc != 100) $display("FAIL mid_sweep_reach: got %0d required 100", cyc); else pass_cnt++;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    count_busy(cyc, rdy);
    total_cnt++;
    if (cyc != SETS_TB) $display("FAIL mid_reset_sweep_len: got %0d required %0d", cyc, SETS_TB); else pass_cnt++;
    model_sweep();
    do_cmd(4'd3, {12'h022, 14'd9, 6'd0}, clr_i_set(), clr_d_set());
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd = '0;
    bus.return_line_i = '0; bus.return_line_d = '0;
    bus2.cmd_valid = 1'b0; bus2.cmd = '0;
    bus2.return_line_i = '0; bus2.return_line_d = '0;
    test_reset();
    test_saturation();
    test_miss_hit();
    test_isolation();
    test_print_illegal();
    test_back_to_back();
    test_clear();
    test_random();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
